// File: rtl/yuv422_fb_scanout_if.sv
// Scan-out controller bundle: timing in, framebuffer read port, aligned video and status out.
interface yuv422_fb_scanout_if #(
  parameter int unsigned ADR_BITS = 20
);
  logic                enable_i;
  logic                de_i;
  logic                hsync_i;
  logic                vsync_i;
  logic [ADR_BITS-1:0] rd_addr_o;
  logic [15:0]         rd_d_i;
  logic [15:0]         pixel_o;
  logic                cb_phase_o;
  logic                de_o;
  logic                hsync_o;
  logic                vsync_o;
  logic                frame_done_o;
  logic                err_line_o;
  logic                err_frame_o;

  // Environment side: timing generator, framebuffer data, formatter
  modport master (
    output enable_i, de_i, hsync_i, vsync_i, rd_d_i,
    input  rd_addr_o, pixel_o, cb_phase_o, de_o, hsync_o, vsync_o,
           frame_done_o, err_line_o, err_frame_o
  );

  // Scan-out controller side
  modport slave (
    input  enable_i, de_i, hsync_i, vsync_i, rd_d_i,
    output rd_addr_o, pixel_o, cb_phase_o, de_o, hsync_o, vsync_o,
           frame_done_o, err_line_o, err_frame_o
  );
endinterface

// File: rtl/yuv422_fb_scanout.sv
// YUV422 framebuffer scan-out: per-pixel read address generation, latency-matched
// sync/DE/pixel alignment, and malformed line/frame reporting.
module yuv422_fb_scanout #(
  parameter int unsigned H_ACTIVE   = 1280,
  parameter int unsigned V_ACTIVE   = 760,
  parameter int unsigned PIXELS     = H_ACTIVE * V_ACTIVE,
  parameter int unsigned RD_LATENCY = 2
) (
  input  logic               clk_i,
  input  logic               rst_i,
  yuv422_fb_scanout_if.slave bus
);
  localparam int unsigned ADR_BITS  = $clog2(PIXELS);
  // line_base must reach PIXELS itself once the frame is exhausted
  localparam int unsigned BASE_BITS = ADR_BITS + 1;
  // x/de counters must represent H_ACTIVE+1 to flag over-long lines
  localparam int unsigned X_BITS    = $clog2(H_ACTIVE + 2);
  localparam int unsigned Y_BITS    = $clog2(V_ACTIVE + 1);
  // delay-line stages ahead of the output register
  localparam int unsigned DLY       = RD_LATENCY + 1;

  localparam logic [15:0]          BLACK      = 16'h8010;
  localparam logic [X_BITS-1:0]    H_LIM      = X_BITS'(H_ACTIVE);
  localparam logic [X_BITS-1:0]    DE_CNT_MAX = X_BITS'(H_ACTIVE + 1);
  localparam logic [Y_BITS-1:0]    V_LIM      = Y_BITS'(V_ACTIVE);
  localparam logic [BASE_BITS-1:0] H_STEP     = BASE_BITS'(H_ACTIVE);

  typedef enum logic [0:0] {S_IDLE, S_ACTIVE} state_e;

  typedef struct packed {
    logic valid;
    logic cb;
    logic de;
    logic hs;
    logic vs;
  } tap_t;

  state_e               state_q, state_d;
  logic                 vs_prev_q, vs_prev_d;
  logic                 de_prev_q, de_prev_d;
  logic [X_BITS-1:0]    x_cnt_q, x_cnt_d;
  logic [X_BITS-1:0]    de_cnt_q, de_cnt_d;
  logic [Y_BITS-1:0]    y_cnt_q, y_cnt_d;
  logic                 y_over_q, y_over_d;
  logic [BASE_BITS-1:0] line_base_q, line_base_d;
  logic [ADR_BITS-1:0]  rd_addr_q, rd_addr_d;
  logic                 frame_done_q, frame_done_d;
  logic                 err_line_q, err_line_d;
  logic                 err_frame_q, err_frame_d;
  tap_t                 pipe_q [DLY];
  tap_t                 pipe_d [DLY];
  logic [15:0]          pixel_q, pixel_d;
  logic                 cb_q, cb_d;
  logic                 de_o_q, de_o_d;
  logic                 hs_q, hs_d;
  logic                 vs_q, vs_d;

  logic                 fs;
  logic                 de_fall;
  tap_t                 tap_new;

  // Scan FSM, pixel/line/frame counters, address generation and status pulses
  always_comb begin
    state_d      = state_q;
    vs_prev_d    = bus.vsync_i;
    de_prev_d    = bus.de_i;
    x_cnt_d      = x_cnt_q;
    de_cnt_d     = de_cnt_q;
    y_cnt_d      = y_cnt_q;
    y_over_d     = y_over_q;
    line_base_d  = line_base_q;
    rd_addr_d    = rd_addr_q;
    frame_done_d = 1'b0;
    err_line_d   = 1'b0;
    err_frame_d  = 1'b0;
    fs           = bus.vsync_i & ~vs_prev_q;
    de_fall      = ~bus.de_i & de_prev_q;
    tap_new      = '{valid: 1'b0, cb: 1'b1, de: bus.de_i, hs: bus.hsync_i, vs: bus.vsync_i};

    unique case (state_q)
      S_IDLE: begin
        x_cnt_d     = '0;
        de_cnt_d    = '0;
        y_cnt_d     = '0;
        y_over_d    = 1'b0;
        line_base_d = '0;
        rd_addr_d   = '0;
        if (fs && bus.enable_i) begin
          state_d = S_ACTIVE;
        end
      end
      S_ACTIVE: begin
        if (bus.de_i) begin
          if (de_cnt_q != DE_CNT_MAX) begin
            de_cnt_d = de_cnt_q + 1'b1;
          end
          if ((x_cnt_q < H_LIM) && (y_cnt_q < V_LIM)) begin
            rd_addr_d     = ADR_BITS'(line_base_q + BASE_BITS'(x_cnt_q));
            tap_new.valid = 1'b1;
            tap_new.cb    = ~x_cnt_q[0];
            x_cnt_d       = x_cnt_q + 1'b1;
          end
        end
        // Line close: short lines still advance by a full line to keep later lines aligned
        if (de_fall) begin
          err_line_d = (de_cnt_q != H_LIM);
          x_cnt_d    = '0;
          de_cnt_d   = '0;
          if (y_cnt_q < V_LIM) begin
            line_base_d = line_base_q + H_STEP;
            y_cnt_d     = y_cnt_q + 1'b1;
          end else begin
            // y_cnt saturates, so extra lines are remembered separately
            y_over_d = 1'b1;
          end
        end
        // Frame close sees the line-updated counters, then everything restarts
        if (fs) begin
          frame_done_d = 1'b1;
          err_frame_d  = (y_cnt_d != V_LIM) || y_over_d;
          x_cnt_d      = '0;
          de_cnt_d     = '0;
          y_cnt_d      = '0;
          y_over_d     = 1'b0;
          line_base_d  = '0;
          rd_addr_d    = '0;
          if (!bus.enable_i) begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Delay line matching the address register plus framebuffer read latency
  always_comb begin
    pipe_d[0] = tap_new;
    for (int unsigned i = 1; i < DLY; i++) begin
      pipe_d[i] = pipe_q[i-1];
    end
  end

  // Output stage: capture read data for valid pixels, black otherwise
  always_comb begin
    pixel_d = pipe_q[DLY-1].valid ? bus.rd_d_i : BLACK;
    cb_d    = pipe_q[DLY-1].valid ? pipe_q[DLY-1].cb : 1'b1;
    de_o_d  = pipe_q[DLY-1].de;
    hs_d    = pipe_q[DLY-1].hs;
    vs_d    = pipe_q[DLY-1].vs;
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= S_IDLE;
      vs_prev_q    <= 1'b0;
      de_prev_q    <= 1'b0;
      x_cnt_q      <= '0;
      de_cnt_q     <= '0;
      y_cnt_q      <= '0;
      y_over_q     <= 1'b0;
      line_base_q  <= '0;
      rd_addr_q    <= '0;
      frame_done_q <= 1'b0;
      err_line_q   <= 1'b0;
      err_frame_q  <= 1'b0;
      for (int unsigned i = 0; i < DLY; i++) begin
        pipe_q[i] <= '0;
      end
      pixel_q      <= BLACK;
      cb_q         <= 1'b1;
      de_o_q       <= 1'b0;
      hs_q         <= 1'b0;
      vs_q         <= 1'b0;
    end else begin
      state_q      <= state_d;
      vs_prev_q    <= vs_prev_d;
      de_prev_q    <= de_prev_d;
      x_cnt_q      <= x_cnt_d;
      de_cnt_q     <= de_cnt_d;
      y_cnt_q      <= y_cnt_d;
      y_over_q     <= y_over_d;
      line_base_q  <= line_base_d;
      rd_addr_q    <= rd_addr_d;
      frame_done_q <= frame_done_d;
      err_line_q   <= err_line_d;
      err_frame_q  <= err_frame_d;
      for (int unsigned i = 0; i < DLY; i++) begin
        pipe_q[i] <= pipe_d[i];
      end
      pixel_q      <= pixel_d;
      cb_q         <= cb_d;
      de_o_q       <= de_o_d;
      hs_q         <= hs_d;
      vs_q         <= vs_d;
    end
  end

  assign bus.rd_addr_o    = rd_addr_q;
  assign bus.pixel_o      = pixel_q;
  assign bus.cb_phase_o   = cb_q;
  assign bus.de_o         = de_o_q;
  assign bus.hsync_o      = hs_q;
  assign bus.vsync_o      = vs_q;
  assign bus.frame_done_o = frame_done_q;
  assign bus.err_line_o   = err_line_q;
  assign bus.err_frame_o  = err_frame_q;

endmodule

// File: doc/yuv422_fb_scanout.md
# yuv422_fb_scanout

Scan-out controller for the YUV422 framebuffer read port. It follows the video timing from the HDMI timing generator and produces the framebuffer read address for every active pixel. It compensates for the framebuffer read latency so that pixel data and delayed sync/DE leave the block aligned, and it reports malformed frames. It sits between the timing generator and the HDMI TX formatter, and is the only driver of the framebuffer `rd_addr_i` port.

## Interface
- `H_ACTIVE`, 1280: active pixels per line.
- `V_ACTIVE`, 760: active lines per frame.
- `PIXELS`, H_ACTIVE*V_ACTIVE: framebuffer depth. Must match the framebuffer instance.
- `RD_LATENCY`, 2: framebuffer read latency in cycles, from address to data. Range 1..4.
- `ADR_BITS` (localparam), $clog2(PIXELS).

Ports:
- `clk_i`, in, 1: pixel clock. The single clock.
- `rst_i`, in, 1: synchronous, active-high reset.
- `enable_i`, in, 1: scan-out enable. Sampled only at frame start.
- `de_i`, in, 1: data enable from the timing generator.
- `hsync_i`, in, 1: hsync from the timing generator. Passed through, polarity untouched.
- `vsync_i`, in, 1: vsync from the timing generator. Active-high.
- `rd_addr_o`, out, ADR_BITS: framebuffer read address.
- `rd_d_i`, in, 16: framebuffer read data. Bits [15:8] are chroma, bits [7:0] are luma.
- `pixel_o`, out, 16: aligned pixel word.
- `cb_phase_o`, out, 1: 1 when the chroma byte of `pixel_o` is Cb, 0 when it is Cr.
- `de_o`, `hsync_o`, `vsync_o`, out, 1 each: delayed timing signals.
- `frame_done_o`, out, 1: one-cycle pulse at the end of every frame scanned in ACTIVE.
- `err_line_o`, out, 1: one-cycle pulse on a malformed line.
- `err_frame_o`, out, 1: one-cycle pulse on a malformed frame.

## Operation
- Frame start (FS): a cycle where `vsync_i`=1 and the registered previous `vsync_i`=0.
- States:
  - IDLE: reset state. On FS with `enable_i`=1, go to ACTIVE.
  - ACTIVE: on FS with `enable_i`=0, go to IDLE. Otherwise stay in ACTIVE.
  - A disable therefore takes effect only at a frame boundary. A frame is never cut mid-way.
- On every FS in ACTIVE, and on entry to ACTIVE: clear `line_base`, `x_cnt`, `y_cnt` and the address.
- Per `de_i`=1 cycle in ACTIVE:
  - If `x_cnt`<H_ACTIVE and `y_cnt`<V_ACTIVE: `rd_addr_o` = `line_base` + `x_cnt`, the pixel is marked valid, and `x_cnt` increments.
  - Otherwise: the pixel is marked invalid and `rd_addr_o` holds its value.
- De falling edge (`de_i`=0, previous `de_i`=1):
  - `line_base` += H_ACTIVE, `y_cnt` += 1, `x_cnt` clears.
  - If that line saw ≠ H_ACTIVE `de_i` cycles, pulse `err_line_o`.
  - A short line still advances `line_base` by exactly H_ACTIVE, so later lines stay aligned.
  - Once `y_cnt`≥V_ACTIVE, `line_base` and `y_cnt` saturate: `line_base` at PIXELS, `y_cnt` at V_ACTIVE.
- At FS ending a frame scanned in ACTIVE:
  - Pulse `frame_done_o`.
  - If `y_cnt`≠V_ACTIVE, also pulse `err_frame_o`. This covers both fewer lines and more lines than V_ACTIVE.
- Output data:
  - `pixel_o` = `rd_d_i` for valid pixels.
  - `pixel_o` = 16'h8010 (black) for invalid pixels, for blanking, and in IDLE.
- `cb_phase_o` is 1 on the first valid pixel of each line and toggles on each following valid pixel. It is 1 when the output is not valid.
- In IDLE, sync and DE still pass through delayed. `rd_addr_o` holds 0 and no status pulses are raised.
- Address arithmetic: ADR_BITS unsigned. The address never exceeds PIXELS-1. There is no wrap.

## Timing
- `rd_addr_o` is registered, valid one cycle after the `de_i` cycle it serves.
- Data path: `rd_d_i` is captured RD_LATENCY cycles after the address, then passes through one output register.
- Total latency from `de_i`/`hsync_i`/`vsync_i` to `de_o`/`hsync_o`/`vsync_o`/`pixel_o`/`cb_phase_o` is RD_LATENCY+2 cycles. The valid mark travels in the same delay line.
- `frame_done_o`, `err_line_o` and `err_frame_o` are registered. They assert the cycle after the detecting edge and are not delayed.
- Reset values:
  - State: IDLE.
  - `rd_addr_o`: 0.
  - `pixel_o`: 16'h8010.
  - `cb_phase_o`: 1.
  - `de_o`, `hsync_o`, `vsync_o`, and all pulses: 0.
  - All delay-line stages: 0.
- Reset mid-frame: the next FS is treated as the first frame. No `frame_done_o` and no error is raised for the partial frame.
- Simultaneous FS and de falling edge: apply the line update first, then the frame check, then clear the counters.

## Test plan
- Nominal 1280x760 frames with `enable_i`=1 and the framebuffer preloaded with addr[15:0]:
  - `pixel_o` at the k-th `de_o` cycle of line y equals (y*1280+k)[15:0].
  - `de_o` lags `de_i` by RD_LATENCY+2.
  - `frame_done_o` pulses once per frame and neither error pulses.
- `enable_i` rises mid-frame: output stays black until the next FS, then frame 1 data starts at address 0. `enable_i` falls mid-frame: the current frame completes, then output is black.
- Line 5 carries 1279 DE cycles:
  - `err_line_o` pulses once.
  - Line 6, pixel 0 reads address 6*1280=7680.
- Frame of 761 lines: the 761st line outputs 16'h8010 and `err_frame_o` pulses at the next FS. Frame of 759 lines: `err_frame_o` pulses and the next frame starts at address 0.
- Reset asserted at line 300:
  - All outputs reach their reset values.
  - The first post-reset FS produces no error.
  - The following frame is scanned fully from address 0.
- RD_LATENCY=1 and RD_LATENCY=4 builds: alignment holds and `cb_phase_o` is 1,0,1,0 from each line's first pixel.
